seg_scan_decoder: RTL

- Reads a multiplexed 6-digit 7-segment display bus (enable, segments, decimal point) and reconstructs the displayed digit values.
- Is the receiving end of the scan interface driven by the display top level.
- Used as an on-chip checker or loopback monitor: samples the scan, waits for each digit pattern to be stable, decodes it to BCD, and publishes a full 6-digit frame once every digit has been captured.

---
 rtl/seg_scan_pkg.sv | 32 +++
 rtl/seg7_to_bcd.sv | 30 +++
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder: segment patterns,
// decode codes, the registered scan sample and the capture FSM encoding.
package seg_scan_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] DIG_BLANK = 4'hF;
   localparam logic [3:0] DIG_ERR   = 4'hE;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic [5:0] enb;
      logic [6:0] seg;
      logic       dp;
   } scan_samp_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to digit decoder; blank maps to DIG_BLANK,
// anything unrecognised maps to DIG_ERR with err raised.
module seg7_to_bcd
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] dig,
   output logic       err
);

   always_comb begin
      dig = DIG_ERR;
      err = 1'b0;
      case (seg)
         SEG_0:     dig = 4'd0;
         SEG_1:     dig = 4'd1;
         SEG_2:     dig = 4'd2;
         SEG_3:     dig = 4'd3;
         SEG_4:     dig = 4'd4;
         SEG_5:     dig = 4'd5;
         SEG_6:     dig = 4'd6;
         SEG_7:     dig = 4'd7;
         SEG_8:     dig = 4'd8;
         SEG_9:     dig = 4'd9;
         SEG_BLANK: dig = DIG_BLANK;
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 6-digit 7-segment scan bus, captures each digit once it
// has been stable for STABLE_CYC samples, and publishes a frame when all six are seen.
//
// state    | meaning
// IDLE     | no single digit enabled on the bus
// SETTLE   | one digit enabled, waiting for the pattern to be stable
// CAPTURED | current pattern already captured, waiting for the bus to change
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int unsigned STABLE_CYC  = 4,
   parameter bit          ENB_ACT_LOW = 1'b0,
   parameter bit          SEG_ACT_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_err,
   output logic        o_frame_vld
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

   scan_samp_t  samp_in, s, p;
   scan_state_t state, state_nxt;
   logic [7:0]  cnt;
   logic [23:0] store, store_nxt;
   logic [5:0]  dpst, dp_nxt, errst, err_nxt, seen, seen_nxt;
   logic [2:0]  idx;
   logic        one_hot, same, capture, frame_done;
   logic [3:0]  dec_dig;
   logic        dec_err;

   assign samp_in.enb = ENB_ACT_LOW ? ~i_seg_enb : i_seg_enb;
   assign samp_in.seg = SEG_ACT_LOW ? ~i_seg     : i_seg;
   assign samp_in.dp  = SEG_ACT_LOW ? ~i_seg_dp  : i_seg_dp;

   assign one_hot = (s.enb != 6'd0) && ((s.enb & (s.enb - 6'd1)) == 6'd0);
   assign same    = (s == p);

   always_comb begin
      idx = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (s.enb[k]) idx = 3'(k);
      end
   end

   seg7_to_bcd u_dec (
      .seg (s.seg),
      .dig (dec_dig),
      .err (dec_err)
   );

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (one_hot) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!one_hot) begin
               state_nxt = IDLE;
            end else if (same && (cnt == CNT_MAX)) begin
               capture   = 1'b1;
               state_nxt = CAPTURED;
            end
         end
         CAPTURED: begin
            if (!one_hot)   state_nxt = IDLE;
            else if (!same) state_nxt = SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Merged view including the digit being captured this cycle, so a frame
   // completion can publish it on the same edge.
   always_comb begin
      store_nxt                      = store;
      store_nxt[{idx, 2'b00} +: 4]   = dec_dig;
      dp_nxt                         = dpst;
      dp_nxt[idx]                    = s.dp;
      err_nxt                        = errst;
      err_nxt[idx]                   = dec_err;
      seen_nxt                       = seen | (6'b000001 << idx);
   end

   assign frame_done = capture && (seen_nxt == 6'h3F);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s     <= '0;
         p     <= '0;
         cnt   <= 8'd0;
         state <= IDLE;
      end else begin
         s     <= samp_in;
         p     <= s;
         state <= state_nxt;
         if (!same)              cnt <= 8'd0;
         else if (cnt < CNT_MAX) cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         store       <= '0;
         dpst        <= '0;
         errst       <= '0;
         seen        <= '0;
         o_digits    <= 24'hFFFFFF;
         o_dp        <= '0;
         o_err       <= '0;
         o_frame_vld <= 1'b0;
      end else begin
         o_frame_vld <= frame_done;
         if (capture) begin
            store <= store_nxt;
            dpst  <= dp_nxt;
            errst <= err_nxt;
            seen  <= frame_done ? 6'd0 : seen_nxt;
         end
         if (frame_done) begin
            o_digits <= store_nxt;
            o_dp     <= dp_nxt;
            o_err    <= err_nxt;
         end
      end
   end

endmodule
